// File: rtl/multi_cycle_ctrl.sv
// Multi-cycle processor control FSM: FETCH/DECODE/EXEC/MEM/WB sequencing with
// memory handshakes, datapath selects and a retired-instruction counter.
module multi_cycle_ctrl #(
   parameter int unsigned CNT_W = 16
) (
   input  logic             clk_i,
   input  logic             rst_i,
   input  logic [5:0]       instr_op_i,
   input  logic             zero_i,
   input  logic             imem_ready_i,
   input  logic             dmem_ready_i,
   output logic             imem_req_o,
   output logic             dmem_req_o,
   output logic             dmem_we_o,
   output logic             pc_write_o,
   output logic             pc_src_o,
   output logic             ir_write_o,
   output logic [1:0]       ALUOp_o,
   output logic             alu_src_b_o,
   output logic             reg_dst_o,
   output logic             mem_to_reg_o,
   output logic             reg_write_o,
   output logic             illegal_o,
   output logic [2:0]       state_o,
   output logic [CNT_W-1:0] retire_cnt_o
);

   typedef enum logic [2:0] {
      FETCH  = 3'd0,
      DECODE = 3'd1,
      EXEC   = 3'd2,
      MEM    = 3'd3,
      WB     = 3'd4
   } state_e;

   localparam logic [5:0] OP_R    = 6'b000000;
   localparam logic [5:0] OP_ADDI = 6'b001000;
   localparam logic [5:0] OP_LW   = 6'b100011;
   localparam logic [5:0] OP_SW   = 6'b101011;
   localparam logic [5:0] OP_BEQ  = 6'b000100;
   localparam logic [5:0] OP_BNE  = 6'b000101;

   state_e           state_q, state_d;
   logic [5:0]       op_q, op_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic             retire;

   logic       imem_req, dmem_req, dmem_we, pc_write, pc_src, ir_write;
   logic [1:0] alu_op;
   logic       alu_src_b, reg_dst, mem_to_reg, reg_write, illegal;

   function automatic logic is_legal(input logic [5:0] op);
      return (op == OP_R) || (op == OP_ADDI) || (op == OP_LW) ||
             (op == OP_SW) || (op == OP_BEQ) || (op == OP_BNE);
   endfunction

   always_comb begin
      state_d    = state_q;
      op_d       = op_q;
      retire     = 1'b0;
      imem_req   = 1'b0;
      dmem_req   = 1'b0;
      dmem_we    = 1'b0;
      pc_write   = 1'b0;
      pc_src     = 1'b0;
      ir_write   = 1'b0;
      alu_op     = 2'b00;
      alu_src_b  = 1'b0;
      reg_dst    = 1'b0;
      mem_to_reg = 1'b0;
      reg_write  = 1'b0;
      illegal    = 1'b0;

      case (state_q)
         FETCH: begin
            imem_req = 1'b1;
            if (imem_ready_i) begin
               ir_write = 1'b1;
               pc_write = 1'b1;
               state_d  = DECODE;
            end
         end
         DECODE: begin
            op_d = instr_op_i;
            if (is_legal(instr_op_i)) begin
               state_d = EXEC;
            end else begin
               illegal = 1'b1;
               state_d = FETCH;
            end
         end
         EXEC: begin
            case (op_q)
               OP_R: begin
                  alu_op  = 2'b10;
                  state_d = WB;
               end
               OP_ADDI: begin
                  alu_src_b = 1'b1;
                  state_d   = WB;
               end
               OP_LW, OP_SW: begin
                  alu_src_b = 1'b1;
                  state_d   = MEM;
               end
               OP_BEQ, OP_BNE: begin
                  alu_op   = 2'b01;
                  pc_src   = 1'b1;
                  pc_write = (op_q == OP_BEQ) ? zero_i : ~zero_i;
                  retire   = 1'b1;
                  state_d  = FETCH;
               end
               default: state_d = FETCH;
            endcase
         end
         MEM: begin
            dmem_req = 1'b1;
            dmem_we  = (op_q == OP_SW);
            if (dmem_ready_i) begin
               retire  = (op_q == OP_SW);
               state_d = (op_q == OP_LW) ? WB : FETCH;
            end
         end
         WB: begin
            reg_write  = 1'b1;
            reg_dst    = (op_q == OP_R);
            mem_to_reg = (op_q == OP_LW);
            retire     = 1'b1;
            state_d    = FETCH;
         end
         default: state_d = FETCH;
      endcase

      cnt_d = retire ? cnt_q + CNT_W'(1) : cnt_q;
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         state_q <= FETCH;
         op_q    <= '0;
         cnt_q   <= '0;
      end else begin
         state_q <= state_d;
         op_q    <= op_d;
         cnt_q   <= cnt_d;
      end
   end

   // Reset silences every output except the visible state, before the edge lands.
   always_comb begin
      imem_req_o   = imem_req   & ~rst_i;
      dmem_req_o   = dmem_req   & ~rst_i;
      dmem_we_o    = dmem_we    & ~rst_i;
      pc_write_o   = pc_write   & ~rst_i;
      pc_src_o     = pc_src     & ~rst_i;
      ir_write_o   = ir_write   & ~rst_i;
      ALUOp_o      = rst_i ? 2'b00 : alu_op;
      alu_src_b_o  = alu_src_b  & ~rst_i;
      reg_dst_o    = reg_dst    & ~rst_i;
      mem_to_reg_o = mem_to_reg & ~rst_i;
      reg_write_o  = reg_write  & ~rst_i;
      illegal_o    = illegal    & ~rst_i;
      state_o      = state_q;
      retire_cnt_o = rst_i ? '0 : cnt_q;
   end

endmodule

// File: tb/tb_multi_cycle_ctrl.sv
// Scoreboard bench for multi_cycle_ctrl: per-instruction expected cycle traces
// are queued by the driver and popped by a per-cycle monitor.
module tb_multi_cycle_ctrl;

   localparam int unsigned CW = 4;

   logic          clk_i = 1'b0;
   logic          rst_i;
   logic [5:0]    instr_op_i;
   logic          zero_i, imem_ready_i, dmem_ready_i;
   logic          imem_req_o, dmem_req_o, dmem_we_o, pc_write_o, pc_src_o, ir_write_o;
   logic [1:0]    ALUOp_o;
   logic          alu_src_b_o, reg_dst_o, mem_to_reg_o, reg_write_o, illegal_o;
   logic [2:0]    state_o;
   logic [CW-1:0] retire_cnt_o;

   multi_cycle_ctrl #(.CNT_W(CW)) dut (
      .clk_i        (clk_i),
      .rst_i        (rst_i),
      .instr_op_i   (instr_op_i),
      .zero_i       (zero_i),
      .imem_ready_i (imem_ready_i),
      .dmem_ready_i (dmem_ready_i),
      .imem_req_o   (imem_req_o),
      .dmem_req_o   (dmem_req_o),
      .dmem_we_o    (dmem_we_o),
      .pc_write_o   (pc_write_o),
      .pc_src_o     (pc_src_o),
      .ir_write_o   (ir_write_o),
      .ALUOp_o      (ALUOp_o),
      .alu_src_b_o  (alu_src_b_o),
      .reg_dst_o    (reg_dst_o),
      .mem_to_reg_o (mem_to_reg_o),
      .reg_write_o  (reg_write_o),
      .illegal_o    (illegal_o),
      .state_o      (state_o),
      .retire_cnt_o (retire_cnt_o)
   );

   always #5 clk_i = ~clk_i;

   // ctl = {imem_req, dmem_req, dmem_we, pc_write, pc_src, ir_write, aluop[1:0],
   //        alu_src_b, reg_dst, mem_to_reg, reg_write, illegal}
   typedef struct packed {
      logic [2:0]    st;
      logic [12:0]   ctl;
      logic [CW-1:0] cnt;
   } exp_t;

   typedef struct packed {
      logic [5:0] op;
      logic       zero;
      logic       imr;
      logic       dmr;
   } drv_t;

   exp_t        exp_q[$];
   exp_t        stg_e[$];
   drv_t        stg_d[$];
   int unsigned model_cnt = 0;
   int unsigned checks = 0;
   int unsigned errors = 0;
   logic        mon_en = 1'b0;

   localparam logic [5:0] LEGAL [6] = '{6'b000000, 6'b001000, 6'b100011,
                                        6'b101011, 6'b000100, 6'b000101};

   function automatic logic rb();
      return 1'($urandom);
   endfunction

   function automatic logic [5:0] rop();
      return 6'($urandom);
   endfunction

   function automatic logic [12:0] mk(input logic imq, input logic dmq, input logic we,
                                      input logic pcw, input logic pcs, input logic irw,
                                      input logic [1:0] aop, input logic asb, input logic rd,
                                      input logic m2r, input logic rw, input logic ill);
      return {imq, dmq, we, pcw, pcs, irw, aop, asb, rd, m2r, rw, ill};
   endfunction

   task automatic stage(input logic [2:0] st, input logic [12:0] ctl, input logic imr,
                        input logic dmr, input logic [5:0] op, input logic zero);
      exp_t e;
      drv_t d;
      e.st  = st;
      e.ctl = ctl;
      e.cnt = CW'(model_cnt);
      d.op  = op;
      d.zero = zero;
      d.imr = imr;
      d.dmr = dmr;
      stg_e.push_back(e);
      stg_d.push_back(d);
   endtask

   task automatic apply(input drv_t d, input logic r);
      instr_op_i   = d.op;
      zero_i       = d.zero;
      imem_ready_i = d.imr;
      dmem_ready_i = d.dmr;
      rst_i        = r;
   endtask

   // Builds the expected cycle-by-cycle trace of one instruction from the ISA rules,
   // queues it, then drives it; abort_at (if inside the trace) applies reset that cycle.
   task automatic run_instr(input logic [5:0] op, input logic zero, input int unsigned wi,
                            input int unsigned wd, input int abort_at);
      logic is_r, addi, lw, sw, beq, bne, br, legal;
      int   n;
      exp_t e;
      is_r  = (op == 6'b000000);
      addi  = (op == 6'b001000);
      lw    = (op == 6'b100011);
      sw    = (op == 6'b101011);
      beq   = (op == 6'b000100);
      bne   = (op == 6'b000101);
      br    = beq | bne;
      legal = is_r | addi | lw | sw | br;
      stg_e.delete();
      stg_d.delete();

      for (int i = 0; i < int'(wi); i++)
         stage(3'd0, mk(1,0,0,0,0,0,2'b00,0,0,0,0,0), 1'b0, rb(), rop(), rb());
      stage(3'd0, mk(1,0,0,1,0,1,2'b00,0,0,0,0,0), 1'b1, rb(), rop(), rb());
      if (!legal) begin
         stage(3'd1, mk(0,0,0,0,0,0,2'b00,0,0,0,0,1), rb(), rb(), op, rb());
      end else begin
         stage(3'd1, '0, rb(), rb(), op, rb());
         stage(3'd2, mk(0,0,0, br & (beq ? zero : ~zero), br, 0,
                        is_r ? 2'b10 : (br ? 2'b01 : 2'b00),
                        addi | lw | sw, 0,0,0,0), rb(), rb(), rop(), zero);
         if (lw | sw) begin
            for (int j = 0; j < int'(wd); j++)
               stage(3'd3, mk(0,1,sw,0,0,0,2'b00,0,0,0,0,0), rb(), 1'b0, rop(), rb());
            stage(3'd3, mk(0,1,sw,0,0,0,2'b00,0,0,0,0,0), rb(), 1'b1, rop(), rb());
         end
         if (is_r | addi | lw)
            stage(3'd4, mk(0,0,0,0,0,0,2'b00,0,is_r,lw,1,0), rb(), rb(), rop(), rb());
      end

      n = stg_e.size();
      if (abort_at >= 0 && abort_at < n) begin
         for (int c = 0; c < abort_at; c++) exp_q.push_back(stg_e[c]);
         e.st  = stg_e[abort_at].st;
         e.ctl = '0;
         e.cnt = '0;
         exp_q.push_back(e);
         for (int c = 0; c <= abort_at; c++) begin
            apply(stg_d[c], (c == abort_at));
            @(posedge clk_i); #1;
         end
         model_cnt = 0;
      end else begin
         foreach (stg_e[c]) exp_q.push_back(stg_e[c]);
         for (int c = 0; c < n; c++) begin
            apply(stg_d[c], 1'b0);
            @(posedge clk_i); #1;
         end
         if (legal) model_cnt = (model_cnt + 1) % (1 << CW);
      end
   endtask

   always @(negedge clk_i) begin
      if (mon_en) begin
         exp_t got, e;
         got = {state_o, imem_req_o, dmem_req_o, dmem_we_o, pc_write_o, pc_src_o,
                ir_write_o, ALUOp_o, alu_src_b_o, reg_dst_o, mem_to_reg_o,
                reg_write_o, illegal_o, retire_cnt_o};
         checks++;
         if (exp_q.size() == 0) begin
            errors++;
            $display("FAIL underflow: DUT cycle with no expectation, got st=%0d ctl=%b cnt=%0d",
                     got.st, got.ctl, got.cnt);
         end else begin
            e = exp_q.pop_front();
            if (got !== e) begin
               errors++;
               $display("FAIL cycle t=%0t: got st=%0d ctl=%b cnt=%0d, expected st=%0d ctl=%b cnt=%0d",
                        $time, got.st, got.ctl, got.cnt, e.st, e.ctl, e.cnt);
            end
         end
      end
   end

   initial begin
      exp_t e;
      int   ab;
      rst_i = 1'b1;
      instr_op_i = '0;
      zero_i = 1'b0;
      imem_ready_i = 1'b0;
      dmem_ready_i = 1'b0;
      @(posedge clk_i); #1;
      e = '0;
      exp_q.push_back(e);
      mon_en = 1'b1;
      imem_ready_i = 1'b1;
      dmem_ready_i = 1'b1;
      @(posedge clk_i); #1;

      run_instr(6'b000000, 1'b0, 0, 0, -1);   // R-type
      run_instr(6'b100011, 1'b0, 0, 3, -1);   // lw with 3 wait cycles
      run_instr(6'b000100, 1'b1, 0, 0, -1);   // beq taken
      run_instr(6'b000101, 1'b1, 0, 0, -1);   // bne not taken
      run_instr(6'b111111, 1'b0, 0, 0, -1);   // illegal
      run_instr(6'b001000, 1'b0, 2, 0, -1);   // addi with imem wait
      run_instr(6'b101011, 1'b0, 0, 2, 4);    // sw reset in MEM
      for (int k = 0; k < 17; k++) run_instr(6'b101011, 1'b0, 0, 0, -1);

      for (int k = 0; k < 300; k++) begin
         logic [5:0] op;
         op = ($urandom_range(0, 6) == 0) ? rop() : LEGAL[$urandom_range(0, 5)];
         ab = ($urandom_range(0, 19) == 0) ? int'($urandom_range(0, 7)) : -1;
         run_instr(op, rb(), $urandom_range(0, 2), $urandom_range(0, 3), ab);
      end

      mon_en = 1'b0;
      checks++;
      if (exp_q.size() != 0) begin
         errors++;
         $display("FAIL leftover: %0d expectations never consumed, required 0", exp_q.size());
      end
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/multi_cycle_ctrl.md
MULTI_CYCLE_CTRL -- requirements
Module: multi_cycle_ctrl

Interface
REQ-001 SHALL have parameter: CNT_W, default 16, width of retired-instruction counter.
REQ-002 SHALL have port: clk_i  input  1  single clock; all state changes on rising edge.
REQ-003 SHALL have port: rst_i  input  1  synchronous, active-high reset.
REQ-004 SHALL have port: instr_op_i  input  6  opcode field of fetched instruction (valid in DECODE).
REQ-005 SHALL have port: zero_i  input  1  ALU zero flag (sampled in EXEC).
REQ-006 SHALL have port: imem_ready_i / dmem_ready_i  input  1 each  memory completion handshakes.
REQ-007 SHALL have port: imem_req_o / dmem_req_o / dmem_we_o  output  1 each  memory requests; dmem_we_o marks store.
REQ-008 SHALL have port: pc_write_o, pc_src_o, ir_write_o  output  1 each  PC update, branch-target select, IR load.
REQ-009 SHALL have port: ALUOp_o  output  2  ALU-control class: 00 add, 01 sub, 10 R-type funct decode.
REQ-010 SHALL have port: alu_src_b_o, reg_dst_o, mem_to_reg_o, reg_write_o  output  1 each  datapath selects/enable.
REQ-011 SHALL have port: illegal_o  output  1  one-cycle pulse on unsupported opcode.
REQ-012 SHALL have port: state_o  output  3  current state; retire_cnt_o  output  CNT_W  retired-instruction count.

Function
REQ-013 SHALL implement states FETCH=0, DECODE=1, EXEC=2, MEM=3, WB=4; codes 5-7 SHALL go to FETCH next cycle.
REQ-014 SHALL support opcodes: R 000000, addi 001000, lw 100011, sw 101011, beq 000100, bne 000101; all others illegal.
REQ-015 FETCH: imem_req_o=1, ALUOp_o=00; when imem_ready_i=1 same cycle: ir_write_o=1, pc_write_o=1, pc_src_o=0, next DECODE; else stay FETCH.
REQ-016 DECODE: latch instr_op_i into internal op register; ALUOp_o=00; legal -> EXEC; illegal -> FETCH with illegal_o=1 this cycle.
REQ-017 EXEC ALUOp_o: R 10; addi/lw/sw 00; beq/bne 01; alu_src_b_o=1 for addi/lw/sw, else 0.
REQ-018 EXEC branch: pc_src_o=1; pc_write_o=(beq & zero_i)|(bne & ~zero_i); next FETCH.
REQ-019 EXEC next state: R/addi -> WB; lw/sw -> MEM.
REQ-020 MEM: dmem_req_o=1, dmem_we_o=(op==sw); hold all outputs stable until dmem_ready_i=1; then lw -> WB, sw -> FETCH.
REQ-021 WB: reg_write_o=1, reg_dst_o=(op==R), mem_to_reg_o=(op==lw); next FETCH.
REQ-022 Latency with zero-wait memories: R/addi/sw 4 cycles, lw 5, beq/bne 3, illegal 2.
REQ-023 Outputs not listed as asserted in a state SHALL be 0; ALUOp_o SHALL be 00 in MEM and WB.
REQ-024 retire_cnt_o SHALL increment by 1 on every transition to FETCH from EXEC (branch), MEM (sw) or WB; never on illegal; wraps 2^CNT_W-1 -> 0.
REQ-025 Memory-ready inputs SHALL be ignored outside their requesting state.

Reset
REQ-026 rst_i=1 at clock edge SHALL force state FETCH, op register 000000, retire_cnt_o 0; rst_i has priority over every transition.
REQ-027 While rst_i=1 all outputs except state_o SHALL be 0 (including imem_req_o); reset mid-instruction SHALL abandon it without retiring.
REQ-028 First cycle after rst_i deasserts SHALL be FETCH with imem_req_o=1.

Verification
REQ-029 R-type (op 000000), ready always 1 -> states 0,1,2,4,0; ALUOp_o=10 in EXEC; reg_write_o=1, reg_dst_o=1 in WB; retire_cnt_o 0->1.
REQ-030 lw with dmem_ready_i low 3 cycles -> MEM held 4 cycles, dmem_we_o=0 throughout, then WB with mem_to_reg_o=1; total 8 cycles.
REQ-031 beq zero_i=1 -> EXEC pc_write_o=1, pc_src_o=1, ALUOp_o=01; bne zero_i=1 -> pc_write_o=0; both retire.
REQ-032 op 111111 -> illegal_o pulse in DECODE, back to FETCH, retire_cnt_o unchanged.
REQ-033 CNT_W=4, 16 retired sw instructions -> retire_cnt_o wraps 15->0.
REQ-034 rst_i asserted in MEM of sw -> next cycle FETCH, dmem_req_o=0, retire_cnt_o=0.
